// File: rtl/uart_mem_dump.sv
// uart_mem_dump: streams a block of 32-bit words from a synchronous-read
// memory out of a UART transmitter (8N1, LSB byte first within each word).
// Optional feature macro: UART_DUMP_CHECKSUM_EN appends a mod-256 sum byte
// of all data bytes after the last word.
module uart_mem_dump #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP, NEXT, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP, NEXT} state_t;
`endif

    state_t            state, next_state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   words_left;
    logic [31:0]       shreg;
    logic              tx_d, done_d;
    logic              accept, bit_end, last_word, word_end, in_frame;
`ifdef UART_DUMP_CHECKSUM_EN
    logic [7:0]        csum;
    logic              csum_phase;
`endif

    // A start pulse that coincides with done is dropped: the dump has not
    // fully retired yet.
    assign accept    = (state == IDLE) && start && !done;
    assign bit_end   = (baud_cnt == BAUD_MAX);
    assign last_word = (words_left == (ADDR_W+1)'(1));
    assign busy      = (state != IDLE);
`ifdef UART_DUMP_CHECKSUM_EN
    assign word_end  = (state == STOP) && bit_end && (byte_cnt == 2'd3) && !csum_phase;
    assign in_frame  = (state == START) || (state == DATA) || (state == STOP) || (state == CSUM);
`else
    assign word_end  = (state == STOP) && bit_end && (byte_cnt == 2'd3);
    assign in_frame  = (state == START) || (state == DATA) || (state == STOP);
`endif

    // Next-state logic; between words NEXT presents the new address and
    // CAPTURE loads it, giving two idle-high cycles on the line.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && (word_count != '0)) next_state = FETCH;
            FETCH:   next_state = CAPTURE;
`ifdef UART_DUMP_CHECKSUM_EN
            CAPTURE: next_state = csum_phase ? CSUM : START;
            CSUM:    if (bit_end) next_state = DATA;
`else
            CAPTURE: next_state = START;
`endif
            START:   if (bit_end) next_state = DATA;
            DATA:    if (bit_end && (bit_cnt == 3'd7)) next_state = STOP;
            STOP: begin
                if (bit_end) begin
                    if (byte_cnt != 2'd3)  next_state = START;
                    else if (!last_word)   next_state = NEXT;
`ifdef UART_DUMP_CHECKSUM_EN
                    else                   next_state = NEXT;
                    if (csum_phase)        next_state = IDLE;
`else
                    else                   next_state = IDLE;
`endif
                end
            end
            NEXT:    next_state = CAPTURE;
            default: next_state = IDLE;
        endcase
    end

    // Line level for the coming cycle, so tx can be driven from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (next_state)
            START: tx_d = 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
            CSUM:  tx_d = 1'b0;
`endif
            DATA:  tx_d = ((state == DATA) && bit_end) ? shreg[1] : shreg[0];
            default: tx_d = 1'b1;
        endcase
        done_d = ((state == STOP) && bit_end && (next_state == IDLE)) ||
                 (accept && (word_count == '0));
    end

    // State, line, counters and data path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            done       <= 1'b0;
            mem_addr   <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            words_left <= '0;
            shreg      <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
        end else begin
            state <= next_state;
            tx    <= tx_d;
            done  <= done_d;

            if (in_frame) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            else          baud_cnt <= '0;

            if (accept) begin
                mem_addr   <= base_addr;
                words_left <= word_count;
                bit_cnt    <= '0;
                byte_cnt   <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
                csum       <= '0;
                csum_phase <= 1'b0;
`endif
            end

            if (state == CAPTURE) begin
`ifdef UART_DUMP_CHECKSUM_EN
                if (csum_phase) begin
                    shreg <= {24'h0, csum};
                end else begin
                    shreg <= mem_rdata;
                    csum  <= csum + mem_rdata[7:0] + mem_rdata[15:8] +
                             mem_rdata[23:16] + mem_rdata[31:24];
                end
`else
                shreg <= mem_rdata;
`endif
            end

            // The 32-bit register shifts straight through all four bytes.
            if ((state == DATA) && bit_end) begin
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
            end

            if ((state == STOP) && bit_end) byte_cnt <= byte_cnt + 2'd1;

            if (word_end) begin
                words_left <= words_left - 1'b1;
                if (!last_word) mem_addr <= mem_addr + 1'b1;
`ifdef UART_DUMP_CHECKSUM_EN
                if (last_word) csum_phase <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump at CLKS_PER_BIT=4: line trace is decoded as a
// UART receiver and compared with bytes/timings derived from memory contents.
module tb_uart_mem_dump;
    localparam int CPB = 4;
    localparam int AW  = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic          tx, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          log_on = 1'b0;
    logic          tr_tx[$];
    logic          tr_busy[$];
    logic          tr_done[$];
    logic [AW-1:0] tr_addr[$];
    logic [7:0]    dec_bytes[$];
    int            dec_starts[$];
    int            dec_bad;

    uart_mem_dump #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    always @(negedge clk) begin
        if (log_on) begin
            tr_tx.push_back(tx);
            tr_busy.push_back(busy);
            tr_done.push_back(done);
            tr_addr.push_back(mem_addr);
        end
    end

    // Pulse start for one edge (cycle N); trace index 0 is cycle N+1.
    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] c);
        @(negedge clk);
        base_addr = b; word_count = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tr_tx.delete(); tr_busy.delete(); tr_done.delete(); tr_addr.delete();
        log_on = 1'b1;
    endtask

    // Software UART receiver over the recorded line trace.
    task automatic decode();
        int i;
        logic [7:0] v;
        logic ok;
        dec_bytes.delete(); dec_starts.delete(); dec_bad = 0; i = 0;
        while (i < tr_tx.size()) begin
            if (tr_tx[i] === 1'b0) begin
                if (i + 10*CPB > tr_tx.size()) begin
                    dec_bad++;
                    i = tr_tx.size();
                end else begin
                    ok = 1'b1;
                    for (int bt = 0; bt < 10; bt++)
                        for (int c = 0; c < CPB; c++)
                            if (tr_tx[i+bt*CPB+c] !== tr_tx[i+bt*CPB]) ok = 1'b0;
                    if (tr_tx[i+9*CPB] !== 1'b1) ok = 1'b0;
                    for (int bt = 0; bt < 8; bt++) v[bt] = tr_tx[i+(bt+1)*CPB];
                    if (!ok) dec_bad++;
                    dec_bytes.push_back(v);
                    dec_starts.push_back(i);
                    i += 10*CPB;
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        base_addr = 14'h0005; word_count = 15'd1; start = 1'b1; rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_tests++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== '0) begin
                n_fail++;
                $display("FAIL reset_state: tx=%b busy=%b done=%b addr=%h, want 1 0 0 0000",
                         tx, busy, done, mem_addr);
            end
        end
        start = 1'b0; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_reset: busy=%b tx=%b, want 0 1", busy, tx);
        end
    endtask

    // inj_at: -1 none, -2 at the done cycle, else trace index for a second start.
    task automatic test_dump(input string name, input logic [AW-1:0] b, input int c,
                             input int inj_at, input logic [AW-1:0] inj_base);
        logic [7:0]    exp_q[$];
        int            exp_st[$];
        logic [7:0]    cs;
        logic [31:0]   wd;
        logic [AW-1:0] a;
        int            done_idx, total, inj, ndone, first_done, nbusy;
        cs = 8'h00;
        for (int w = 0; w < c; w++) begin
            a  = b + w[AW-1:0];
            wd = mem[a];
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(wd[8*k +: 8]);
                exp_st.push_back(2 + w*(40*CPB + 2) + k*10*CPB);
                cs = cs + wd[8*k +: 8];
            end
        end
        done_idx = 2 + c*40*CPB + 2*(c-1);
`ifdef UART_DUMP_CHECKSUM_EN
        exp_q.push_back(cs);
        exp_st.push_back(done_idx + 2);
        done_idx += 2 + 10*CPB;
`endif
        total = done_idx + 20;
        inj = (inj_at == -2) ? done_idx : inj_at;
        launch(b, c[AW:0]);
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            start = (i == inj) ? 1'b1 : 1'b0;
            if (i == inj) base_addr = inj_base;
        end
        start = 1'b0;
        #1 log_on = 1'b0;
        decode();

        n_tests++;
        if (dec_bad != 0) begin
            n_fail++;
            $display("FAIL %s frame: %0d malformed frames, want 0", name, dec_bad);
        end
        n_tests++;
        if (dec_bytes.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s byte_count: got %0d, want %0d", name, dec_bytes.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < dec_bytes.size()) begin
                n_tests++;
                if (dec_bytes[k] !== exp_q[k] || dec_starts[k] != exp_st[k]) begin
                    n_fail++;
                    $display("FAIL %s byte%0d: got %h at %0d, want %h at %0d", name, k,
                             dec_bytes[k], dec_starts[k], exp_q[k], exp_st[k]);
                end
            end
        end
        ndone = 0; first_done = -1; nbusy = 0;
        for (int i = 0; i < tr_done.size(); i++) begin
            if (tr_done[i] === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = i;
            end
            if (tr_busy[i] === 1'b1) nbusy++;
        end
        n_tests++;
        if (ndone != 1 || first_done != done_idx) begin
            n_fail++;
            $display("FAIL %s done: %0d pulses first at %0d, want 1 at %0d",
                     name, ndone, first_done, done_idx);
        end
        n_tests++;
        if (nbusy != done_idx || tr_busy[0] !== 1'b1 || tr_busy[done_idx-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: %0d busy cycles, want %0d contiguous from 0",
                     name, nbusy, done_idx);
        end
        n_tests++;
        if (tr_addr[0] !== b) begin
            n_fail++;
            $display("FAIL %s first_addr: got %h, want %h", name, tr_addr[0], b);
        end
        if (c >= 2) begin
            a = b + 1'b1;
            n_tests++;
            if (tr_addr[exp_st[4]] !== a) begin
                n_fail++;
                $display("FAIL %s next_addr: got %h, want %h", name, tr_addr[exp_st[4]], a);
            end
        end
    endtask

    task automatic test_zero_length();
        int nb, nd, nlow;
        launch(14'($urandom), 15'd0);
        repeat (30) @(negedge clk);
        #1 log_on = 1'b0;
        nb = 0; nd = 0; nlow = 0;
        for (int i = 0; i < tr_tx.size(); i++) begin
            if (tr_busy[i] === 1'b1) nb++;
            if (tr_done[i] === 1'b1) nd++;
            if (tr_tx[i] !== 1'b1) nlow++;
        end
        n_tests++;
        if (tr_done[0] !== 1'b1 || nd != 1) begin
            n_fail++;
            $display("FAIL zero_done: done[0]=%b pulses=%0d, want 1 and 1", tr_done[0], nd);
        end
        n_tests++;
        if (nb != 0 || nlow != 0) begin
            n_fail++;
            $display("FAIL zero_line: busy cycles=%0d tx low cycles=%0d, want 0 0", nb, nlow);
        end
    endtask

    task automatic test_reset_mid_byte();
        int nd, bad_after;
        launch(14'h0123, 15'd2);
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 55) rst_n = 1'b0;
            if (i == 58) rst_n = 1'b1;
        end
        #1 log_on = 1'b0;
        nd = 0; bad_after = 0;
        for (int i = 0; i < tr_tx.size(); i++) begin
            if (tr_done[i] === 1'b1) nd++;
            if (i >= 56 && (tr_tx[i] !== 1'b1 || tr_busy[i] !== 1'b0)) bad_after++;
        end
        n_tests++;
        if (tr_busy[54] !== 1'b1 || tr_tx[56] !== 1'b1 || tr_busy[56] !== 1'b0 || tr_addr[56] !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy_before=%b tx=%b busy=%b addr=%h, want 1 1 0 0000",
                     tr_busy[54], tr_tx[56], tr_busy[56], tr_addr[56]);
        end
        n_tests++;
        if (nd != 0 || bad_after != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: done pulses=%0d active cycles after reset=%0d, want 0 0",
                     nd, bad_after);
        end
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
        mem[14'h0010] = 32'h12345678;
        test_reset();
        test_dump("single_word", 14'h0010, 1, -1, '0);
        test_dump("wrap", 14'h3FFF, 2, -1, '0);
        test_zero_length();
        test_dump("busy_start", 14'h0020, 2, 70, 14'h0100);
        test_dump("start_at_done", 14'h0030, 1, -2, 14'h0040);
        test_reset_mid_byte();
        test_dump("replay", 14'h0200, 1, -1, '0);
        for (int r = 0; r < 3; r++)
            test_dump("random", 14'($urandom), int'($urandom_range(1, 3)), -1, '0);
`ifdef UART_DUMP_CHECKSUM_EN
        mem[14'h0050] = 32'h01020304;
        mem[14'h0051] = 32'hFFFFFFFF;
        test_dump("csum_a", 14'h0050, 1, -1, '0);
        test_dump("csum_b", 14'h0051, 1, -1, '0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
